mc_ctrl: RTL and testbench

//  Multi-cycle MIPS controller. Sequences the fetch/decode/exec/mem/wb datapath
//  and drives every control input of it, including the immediate extender's
//  EOp select. It takes opcode/funct from the held IR and the ALU zero flag.
//  It asserts exactly the write enables that are legal in each state.

---
 rtl/mc_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mc_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS controller: FETCH/DECODE/EXEC/MEM/WB sequencing with combinational control outputs.
// Optional feature: define MC_ILLEGAL_TRAP_EN to trap illegal instructions into a sticky HALT state.
module mc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RegWr,
  output logic       MemWr,
  output logic [1:0] EOp,
  output logic       ALUSrc,
  output logic [2:0] ALUOp,
  output logic [1:0] RegDst,
  output logic [1:0] WDSel,
  output logic [1:0] NPCOp,
  output logic       instr_done,
  output logic [2:0] state,
  output logic       illegal
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_PASS = 3'b011;

  state_t cur, nxt;

  logic is_addu, is_subu, is_rtype, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, legal;
  assign is_addu  = (opcode == OP_RTYPE) && (funct == FN_ADDU);
  assign is_subu  = (opcode == OP_RTYPE) && (funct == FN_SUBU);
  assign is_rtype = is_addu || is_subu;
  assign is_ori   = (opcode == OP_ORI);
  assign is_lui   = (opcode == OP_LUI);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_j     = (opcode == OP_J);
  assign legal    = is_rtype || is_ori || is_lui || is_lw || is_sw || is_beq || is_j;

  // EXEC-phase ALU/extender selects; MEM and WB keep driving the same values.
  logic [1:0] ex_eop;
  logic       ex_alusrc;
  logic [2:0] ex_aluop;
  always_comb begin
    ex_eop    = 2'b00;
    ex_alusrc = 1'b0;
    ex_aluop  = ALU_ADD;
    if (is_subu) ex_aluop = ALU_SUB;
    if (is_ori) begin
      ex_eop = 2'b01; ex_alusrc = 1'b1; ex_aluop = ALU_OR;
    end
    if (is_lui) begin
      ex_eop = 2'b10; ex_alusrc = 1'b1; ex_aluop = ALU_PASS;
    end
    if (is_lw || is_sw) begin
      ex_eop = 2'b00; ex_alusrc = 1'b1; ex_aluop = ALU_ADD;
    end
    if (is_beq) begin
      ex_eop = 2'b11; ex_alusrc = 1'b0; ex_aluop = ALU_SUB;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= S_FETCH;
    else       cur <= nxt;
  end

`ifdef MC_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             illegal_q <= 1'b0;
    else if ((cur == S_DECODE) && !legal)  illegal_q <= 1'b1;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        if (is_j)       nxt = S_FETCH;
        else if (legal) nxt = S_EXEC;
`ifdef MC_ILLEGAL_TRAP_EN
        else            nxt = S_HALT;
`else
        else            nxt = S_FETCH;
`endif
      end
      S_EXEC: begin
        if (is_beq)             nxt = S_FETCH;
        else if (is_lw || is_sw) nxt = S_MEM;
        else                    nxt = S_WB;
      end
      S_MEM:  nxt = is_sw ? S_FETCH : S_WB;
      S_WB:   nxt = S_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
      S_HALT: nxt = S_HALT;
`else
      S_HALT: nxt = S_FETCH;
`endif
      default: nxt = S_FETCH;
    endcase
  end

  always_comb begin
    PCWr = 1'b0; IRWr = 1'b0; RegWr = 1'b0; MemWr = 1'b0;
    EOp = 2'b00; ALUSrc = 1'b0; ALUOp = ALU_ADD;
    RegDst = 2'b00; WDSel = 2'b00; NPCOp = 2'b00; instr_done = 1'b0;
    case (cur)
      S_FETCH: begin
        IRWr = 1'b1; PCWr = 1'b1; NPCOp = 2'b00;
      end
      S_DECODE: begin
        EOp = 2'b11;
        if (is_j) begin
          PCWr = 1'b1; NPCOp = 2'b10; instr_done = 1'b1;
        end
`ifndef MC_ILLEGAL_TRAP_EN
        else if (!legal) instr_done = 1'b1;
`endif
      end
      S_EXEC: begin
        EOp = ex_eop; ALUSrc = ex_alusrc; ALUOp = ex_aluop;
        if (is_beq) begin
          NPCOp = 2'b01; PCWr = zero; instr_done = 1'b1;
        end
      end
      S_MEM: begin
        EOp = ex_eop; ALUSrc = ex_alusrc; ALUOp = ex_aluop;
        if (is_sw) begin
          MemWr = 1'b1; instr_done = 1'b1;
        end
      end
      S_WB: begin
        EOp = ex_eop; ALUSrc = ex_alusrc; ALUOp = ex_aluop;
        RegWr = 1'b1; instr_done = 1'b1;
        RegDst = is_rtype ? 2'b01 : 2'b00;
        WDSel  = is_lw ? 2'b01 : 2'b00;
      end
      default: ;
    endcase
    // Reset already holds cur at FETCH; this also silences the FETCH enables.
    if (reset) begin
      PCWr = 1'b0; IRWr = 1'b0; RegWr = 1'b0; MemWr = 1'b0;
      EOp = 2'b00; ALUSrc = 1'b0; ALUOp = ALU_ADD;
      RegDst = 2'b00; WDSel = 2'b00; NPCOp = 2'b00; instr_done = 1'b0;
    end
  end

  assign state = cur;
endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: table of instruction traces fed through an expected-word queue, plus reset and illegal sequences.
module tb_mc_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero;
  logic       PCWr, IRWr, RegWr, MemWr, ALUSrc, instr_done, illegal;
  logic [1:0] EOp, RegDst, WDSel, NPCOp;
  logic [2:0] ALUOp, state;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr), .MemWr(MemWr), .EOp(EOp),
    .ALUSrc(ALUSrc), .ALUOp(ALUOp), .RegDst(RegDst), .WDSel(WDSel),
    .NPCOp(NPCOp), .instr_done(instr_done), .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam int W = 21;
  logic [W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  // {illegal, state, PCWr, IRWr, RegWr, MemWr, EOp, ALUSrc, ALUOp, RegDst, WDSel, NPCOp, instr_done}
  function automatic logic [W-1:0] pk(input logic [2:0] st, input logic pc, input logic ir,
                                      input logic rw, input logic mw, input logic [1:0] eop,
                                      input logic asrc, input logic [2:0] aop, input logic [1:0] rd,
                                      input logic [1:0] wd, input logic [1:0] np, input logic dn,
                                      input logic il);
    return {il, st, pc, ir, rw, mw, eop, asrc, aop, rd, wd, np, dn};
  endfunction

  typedef struct {
    string           name;
    logic [5:0]      op;
    logic [5:0]      fn;
    logic            zc;
    logic            zv;
    logic            ill;
    int              n;
    logic [4:0][W-1:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic check_cycle(input string name, input int idx, input logic zc, input logic zv);
    logic [W-1:0] got, want;
    zero = (zc && idx == 2) ? zv : 1'($urandom_range(0, 1));
    @(negedge clk);
    got = {illegal, state, PCWr, IRWr, RegWr, MemWr, EOp, ALUSrc, ALUOp, RegDst, WDSel, NPCOp, instr_done};
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h but no expected word queued", name, idx, got);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        fails++;
        $display("FAIL %s cycle %0d: got %h want %h", name, idx, got, want);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input int k);
    opcode = vecs[k].op;
    funct  = vecs[k].fn;
    for (int i = 0; i < vecs[k].n; i++) exp_q.push_back(vecs[k].exp[i]);
    for (int i = 0; i < vecs[k].n; i++) check_cycle(vecs[k].name, i, vecs[k].zc, vecs[k].zv);
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  logic [W-1:0] wf, wz, ill_d;

  initial begin
    wf = pk(0, 1, 1, 0, 0, 2'd0, 0, 3'd0, 2'd0, 2'd0, 2'd0, 0, 0);
    wz = '0;
`ifdef MC_ILLEGAL_TRAP_EN
    ill_d = pk(1, 0, 0, 0, 0, 2'd3, 0, 3'd0, 2'd0, 2'd0, 2'd0, 0, 0);
`else
    ill_d = pk(1, 0, 0, 0, 0, 2'd3, 0, 3'd0, 2'd0, 2'd0, 2'd0, 1, 0);
`endif
    vecs[0] = '{"addu", 6'h00, 6'h21, 0, 0, 0, 4, '{default: '0}};
    vecs[0].exp = {wz,
      pk(4, 0, 0, 1, 0, 2'd0, 0, 3'd0, 2'd1, 2'd0, 2'd0, 1, 0),
      pk(2, 0, 0, 0, 0, 2'd0, 0, 3'd0, 2'd0, 2'd0, 2'd0, 0, 0),
      pk(1, 0, 0, 0, 0, 2'd3, 0, 3'd0, 2'd0, 2'd0, 2'd0, 0, 0), wf};
    vecs[1] = '{"subu", 6'h00, 6'h23, 0, 0, 0, 4, '{default: '0}};
    vecs[1].exp = {wz,
      pk(4, 0, 0, 1, 0, 2'd0, 0, 3'd1, 2'd1, 2'd0, 2'd0, 1, 0),
      pk(2, 0, 0, 0, 0, 2'd0, 0, 3'd1, 2'd0, 2'd0, 2'd0, 0, 0),
      pk(1, 0, 0, 0, 0, 2'd3, 0, 3'd0, 2'd0, 2'd0, 2'd0, 0, 0), wf};
    vecs[2] = '{"ori", 6'h0D, 6'h00, 0, 0, 0, 4, '{default: '0}};
    vecs[2].exp = {wz,
      pk(4, 0, 0, 1, 0, 2'd1, 1, 3'd2, 2'd0, 2'd0, 2'd0, 1, 0),
      pk(2, 0, 0, 0, 0, 2'd1, 1, 3'd2, 2'd0, 2'd0, 2'd0, 0, 0),
      pk(1, 0, 0, 0, 0, 2'd3, 0, 3'd0, 2'd0, 2'd0, 2'd0, 0, 0), wf};
    vecs[3] = '{"lui", 6'h0F, 6'h21, 0, 0, 0, 4, '{default: '0}};
    vecs[3].exp = {wz,
      pk(4, 0, 0, 1, 0, 2'd2, 1, 3'd3, 2'd0, 2'd0, 2'd0, 1, 0),
      pk(2, 0, 0, 0, 0, 2'd2, 1, 3'd3, 2'd0, 2'd0, 2'd0, 0, 0),
      pk(1, 0, 0, 0, 0, 2'd3, 0, 3'd0, 2'd0, 2'd0, 2'd0, 0, 0), wf};
    vecs[4] = '{"lw", 6'h23, 6'h00, 0, 0, 0, 5, '{default: '0}};
    vecs[4].exp = {
      pk(4, 0, 0, 1, 0, 2'd0, 1, 3'd0, 2'd0, 2'd1, 2'd0, 1, 0),
      pk(3, 0, 0, 0, 0, 2'd0, 1, 3'd0, 2'd0, 2'd0, 2'd0, 0, 0),
      pk(2, 0, 0, 0, 0, 2'd0, 1, 3'd0, 2'd0, 2'd0, 2'd0, 0, 0),
      pk(1, 0, 0, 0, 0, 2'd3, 0, 3'd0, 2'd0, 2'd0, 2'd0, 0, 0), wf};
    vecs[5] = '{"sw", 6'h2B, 6'h00, 0, 0, 0, 4, '{default: '0}};
    vecs[5].exp = {wz,
      pk(3, 0, 0, 0, 1, 2'd0, 1, 3'd0, 2'd0, 2'd0, 2'd0, 1, 0),
      pk(2, 0, 0, 0, 0, 2'd0, 1, 3'd0, 2'd0, 2'd0, 2'd0, 0, 0),
      pk(1, 0, 0, 0, 0, 2'd3, 0, 3'd0, 2'd0, 2'd0, 2'd0, 0, 0), wf};
    vecs[6] = '{"beq_taken", 6'h04, 6'h00, 1, 1, 0, 3, '{default: '0}};
    vecs[6].exp = {wz, wz,
      pk(2, 1, 0, 0, 0, 2'd3, 0, 3'd1, 2'd0, 2'd0, 2'd1, 1, 0),
      pk(1, 0, 0, 0, 0, 2'd3, 0, 3'd0, 2'd0, 2'd0, 2'd0, 0, 0), wf};
    vecs[7] = '{"beq_not_taken", 6'h04, 6'h00, 1, 0, 0, 3, '{default: '0}};
    vecs[7].exp = {wz, wz,
      pk(2, 0, 0, 0, 0, 2'd3, 0, 3'd1, 2'd0, 2'd0, 2'd1, 1, 0),
      pk(1, 0, 0, 0, 0, 2'd3, 0, 3'd0, 2'd0, 2'd0, 2'd0, 0, 0), wf};
    vecs[8] = '{"j", 6'h02, 6'h00, 0, 0, 0, 2, '{default: '0}};
    vecs[8].exp = {wz, wz, wz,
      pk(1, 1, 0, 0, 0, 2'd3, 0, 3'd0, 2'd0, 2'd0, 2'd2, 1, 0), wf};
    vecs[9] = '{"illegal_op", 6'h3F, 6'h00, 0, 0, 1, 2, '{default: '0}};
    vecs[9].exp = {wz, wz, wz, ill_d, wf};
    vecs[10] = '{"illegal_funct", 6'h00, 6'h20, 0, 0, 1, 2, '{default: '0}};
    vecs[10].exp = {wz, wz, wz, ill_d, wf};

    // Clock/reset: outputs all zero while reset is held.
    reset = 1'b1; opcode = 6'h0D; funct = 6'h00; zero = 1'b0;
    #1;
    exp_q.push_back(wz); check_cycle("reset_hold", 0, 0, 0);
    exp_q.push_back(wz); check_cycle("reset_hold", 1, 0, 0);
    reset = 1'b0;

    // Table pass in order, then a randomised pass.
    for (int k = 0; k < 11; k++) begin
`ifdef MC_ILLEGAL_TRAP_EN
      if (vecs[k].ill) continue;
`endif
      apply_vec(k);
    end
    for (int r = 0; r < 30; r++) begin
      int k;
      k = $urandom_range(0, 10);
`ifdef MC_ILLEGAL_TRAP_EN
      if (vecs[k].ill) k = 2;
`endif
      apply_vec(k);
    end

    // Reset asserted mid-EXEC aborts the instruction immediately.
    opcode = 6'h0D; funct = 6'h00;
    exp_q.push_back(vecs[2].exp[0]); check_cycle("rst_mid_exec", 0, 0, 0);
    exp_q.push_back(vecs[2].exp[1]); check_cycle("rst_mid_exec", 1, 0, 0);
    #2 reset = 1'b1;
    #1;
    check_bit("rst_async_state0", (state == 3'd0), 1'b1);
    check_bit("rst_async_enables", (PCWr | IRWr | RegWr | MemWr | instr_done), 1'b0);
    exp_q.push_back(wz); check_cycle("rst_mid_exec_hold", 0, 0, 0);
    exp_q.push_back(wz); check_cycle("rst_mid_exec_hold", 1, 0, 0);
    reset = 1'b0;
    apply_vec(2);

    // Illegal opcode: trap into HALT, or retire as a NOP.
    opcode = 6'h3F; funct = 6'h00;
    exp_q.push_back(wf); check_cycle("illegal_seq", 0, 0, 0);
    exp_q.push_back(ill_d); check_cycle("illegal_seq", 1, 0, 0);
`ifdef MC_ILLEGAL_TRAP_EN
    opcode = 6'h0D;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(pk(5, 0, 0, 0, 0, 2'd0, 0, 3'd0, 2'd0, 2'd0, 2'd0, 0, 1));
      check_cycle("illegal_halt", i + 2, 0, 0);
    end
    reset = 1'b1;
    #1;
    check_bit("illegal_cleared_by_reset", illegal, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    apply_vec(2);
`else
    apply_vec(8);
    check_bit("illegal_tied_low", illegal, 1'b0);
`endif

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL leftover_queue: got %0d entries want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
